// File: rtl/lsu_initiator_if.sv
// Purpose: bundles the execute-side op handshake, data-memory request/response
//          and writeback/stall signals of the load/store initiator.
// Latency: none (wires only).
// Backpressure: op side uses op_valid/op_ready; memory side uses mem_req/mem_gnt.
// Modports: master = the initiator itself, slave = its environment
//           (execute stage, memory, writeback).
interface lsu_initiator_if #(
    parameter int ADDR_W = 32
);
    // execute stage -> initiator
    logic              op_valid;
    logic              op_ready;
    logic              op_is_store;
    logic [2:0]        op_funct3;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [4:0]        op_rd;
    // initiator <-> data memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    // initiator -> writeback / pipeline control
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              stall;
    logic              err_pulse;

    modport master (
        input  op_valid, op_is_store, op_funct3, op_addr, op_wdata, op_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output op_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_data, stall, err_pulse
    );

    modport slave (
        output op_valid, op_is_store, op_funct3, op_addr, op_wdata, op_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  op_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_data, stall, err_pulse
    );
endinterface

// File: rtl/lsu_initiator.sv
// Purpose: RV32I load/store initiator; turns one decoded op into one or two
//          word-aligned memory beats with byte enables and returns extended load data.
// Latency: aligned store 1 cycle, split store 2; load wb_valid 2 cycles after the
//          last rvalid-free path (gnt c1, rvalid c2 -> wb c3; split -> wb c5).
// Backpressure: op_ready only in IDLE, stall while busy; beats held until mem_gnt.
// Ports: clk, reset (async active-high), bus (lsu_initiator_if.master).
module lsu_initiator #(
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    lsu_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic [31:0]       lo_q, hi_q;

    logic              accept;
    logic              in_legal;
    logic              in_split;
    logic              in_reject;
    logic              lo_cap, hi_cap;

    logic [7:0]        mask_q;
    logic              split_q;
    logic [63:0]       wdata64;
    logic [31:0]       rd_shifted;
    logic [ADDR_W-1:0] word_base;

    logic              mem_req_c, mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [3:0]        mem_be_c;
    logic [31:0]       mem_wdata_c;
    logic              wb_valid_c;
    logic [4:0]        wb_rd_c;
    logic [31:0]       wb_data_c;

    // Byte-lane mask over two consecutive words for a 1/2/4-byte access.
    function automatic logic [7:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] base;
        case (f3[1:0])
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    assign accept = bus.op_valid && (state_q == S_IDLE);

    always_comb begin
        in_legal = 1'b1;
        if (bus.op_is_store) begin
            in_legal = (bus.op_funct3 == 3'b000) || (bus.op_funct3 == 3'b001) ||
                       (bus.op_funct3 == 3'b010);
        end else begin
            in_legal = !((bus.op_funct3 == 3'b011) || (bus.op_funct3 == 3'b110) ||
                         (bus.op_funct3 == 3'b111));
        end
    end

    // Word crossing happens only for a halfword at offset 3 or a word at a
    // non-zero offset; bytes never cross.
    assign in_split  = ((bus.op_funct3[1:0] == 2'b01) && (bus.op_addr[1:0] == 2'b11)) ||
                       ((bus.op_funct3[1:0] == 2'b10) && (bus.op_addr[1:0] != 2'b00));
    assign in_reject = !in_legal || (!ALLOW_MISALIGNED && in_split);

    assign mask_q    = byte_mask(funct3_q, addr_q[1:0]);
    assign split_q   = |mask_q[7:4];
    assign wdata64   = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    assign word_base = {addr_q[ADDR_W-1:2], 2'b00};
    // Only the low 8n bits of the realigned pair are ever consumed.
    assign rd_shifted = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        lo_cap      = 1'b0;
        hi_cap      = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_be_c    = 4'b0000;
        mem_wdata_c = 32'b0;
        wb_valid_c  = 1'b0;
        wb_rd_c     = 5'd0;
        wb_data_c   = 32'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_reject) err_d = 1'b1;
                    else           state_d = S_REQ0;
                end
            end
            S_REQ0: begin
                mem_req_c   = 1'b1;
                mem_we_c    = is_store_q;
                mem_addr_c  = word_base;
                mem_be_c    = mask_q[3:0];
                mem_wdata_c = is_store_q ? wdata64[31:0] : 32'b0;
                if (bus.mem_gnt) begin
                    if (is_store_q) state_d = split_q ? S_REQ1 : S_IDLE;
                    else            state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (bus.mem_rvalid) begin
                    lo_cap  = 1'b1;
                    state_d = split_q ? S_REQ1 : S_RESP;
                end
            end
            S_REQ1: begin
                mem_req_c   = 1'b1;
                mem_we_c    = is_store_q;
                mem_addr_c  = word_base + ADDR_W'(4);
                mem_be_c    = mask_q[7:4];
                mem_wdata_c = is_store_q ? wdata64[63:32] : 32'b0;
                if (bus.mem_gnt) state_d = is_store_q ? S_IDLE : S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.mem_rvalid) begin
                    hi_cap  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                wb_valid_c = 1'b1;
                wb_rd_c    = rd_q;
                case (funct3_q)
                    3'b000:  wb_data_c = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                    3'b001:  wb_data_c = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                    3'b100:  wb_data_c = {24'b0, rd_shifted[7:0]};
                    3'b101:  wb_data_c = {16'b0, rd_shifted[15:0]};
                    default: wb_data_c = rd_shifted;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            rd_q       <= 5'd0;
            lo_q       <= 32'b0;
            hi_q       <= 32'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                is_store_q <= bus.op_is_store;
                funct3_q   <= bus.op_funct3;
                addr_q     <= bus.op_addr;
                wdata_q    <= bus.op_wdata;
                rd_q       <= bus.op_rd;
            end
            if (lo_cap) lo_q <= bus.mem_rdata;
            if (hi_cap) hi_q <= bus.mem_rdata;
        end
    end

    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.stall     = (state_q != S_IDLE) || err_q;
    assign bus.err_pulse = err_q;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_be    = mem_be_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.wb_valid  = wb_valid_c;
    assign bus.wb_rd     = wb_rd_c;
    assign bus.wb_data   = wb_data_c;

endmodule

// File: tb/tb_lsu_initiator.sv
// Purpose: self-checking bench for lsu_initiator with a byte-level memory model.
// Latency: observes every cycle 1 time unit after the rising edge.
// Backpressure: responder inserts programmable gnt and rvalid delays.
module tb_lsu_initiator;
    localparam int AW = 32;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    lsu_initiator_if #(.ADDR_W(AW)) bus ();

    lsu_initiator #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // ram: what the responder serves/updates; ref_mem: reference byte memory
    logic [7:0]  ram     [int];
    logic [7:0]  ref_mem [int];

    logic [31:0] bt_addr  [$];
    logic [31:0] bt_wdata [$];
    logic [3:0]  bt_be    [$];
    logic        bt_we    [$];
    int          wb_cnt, err_cnt, wb_cyc, done_cyc;
    logic [31:0] wb_dat;
    logic [4:0]  wb_rd_s;
    bit          unstable, stall_gap, timed_out, req_after;
    int          gnt_dly, rv_dly;
    bit          gnt_noise;

    // ---------------- reference model (byte granular) ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m = 32'b0;
        for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
        return m;
    endfunction

    // Which words and lanes the bytes addr..addr+n-1 touch, with store data per lane.
    function automatic void model_beats(input logic [31:0] addr, input int n, input logic [31:0] wd,
                                        output int nb, output logic [31:0] wa0, output logic [31:0] wa1,
                                        output logic [3:0] be0, output logic [3:0] be1,
                                        output logic [31:0] d0, output logic [31:0] d1);
        logic [31:0] a;
        wa0 = addr & ~32'd3;
        wa1 = wa0 + 32'd4;
        nb = 1; be0 = 4'b0; be1 = 4'b0; d0 = 32'b0; d1 = 32'b0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if ((a & ~32'd3) == wa0) begin
                be0[a[1:0]] = 1'b1;
                d0[8*a[1:0] +: 8] = wd[8*i +: 8];
            end else begin
                nb = 2;
                be1[a[1:0]] = 1'b1;
                d1[8*a[1:0] +: 8] = wd[8*i +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v = 32'b0;
        int n = size_of(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
    endfunction

    function automatic void set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            ram[a + i]     = w[8*i +: 8];
            ref_mem[a + i] = w[8*i +: 8];
        end
    endfunction

    // ---------------- driver + memory responder ----------------
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd);
        int cyc, wait_n;
        bit done, prev_ng;
        logic [31:0] pa, pw, w;
        logic [3:0]  pb;
        logic        pwe;
        int          rv_at [$];
        logic [31:0] rv_dat [$];
        bt_addr.delete(); bt_wdata.delete(); bt_be.delete(); bt_we.delete();
        wb_cnt = 0; err_cnt = 0; wb_cyc = -1; done_cyc = -1; wb_dat = 32'bx; wb_rd_s = 5'bx;
        unstable = 0; stall_gap = 0; req_after = 0;
        pa = 0; pw = 0; pb = 0; pwe = 0;
        bus.op_valid = 1'b1; bus.op_is_store = st; bus.op_funct3 = f3;
        bus.op_addr = addr; bus.op_wdata = wd; bus.op_rd = rd;
        cyc = 0; done = 0; wait_n = 0; prev_ng = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            bus.op_valid = 1'b0; bus.op_funct3 = 3'($urandom); bus.op_addr = $urandom;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            if (!bus.op_ready && !bus.stall) stall_gap = 1;
            if (bus.err_pulse) begin
                err_cnt++;
                if (!bus.stall) stall_gap = 1;
            end
            if (bus.wb_valid) begin
                wb_cnt++; wb_dat = bus.wb_data; wb_rd_s = bus.wb_rd; wb_cyc = cyc;
            end
            if (rv_at.size() > 0 && rv_at[0] == cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rv_dat.pop_front();
                void'(rv_at.pop_front());
            end
            if (bus.mem_req) begin
                if (prev_ng && (bus.mem_addr !== pa || bus.mem_be !== pb ||
                                bus.mem_we !== pwe || bus.mem_wdata !== pw)) unstable = 1;
                if (wait_n >= gnt_dly) begin
                    bus.mem_gnt = 1'b1;
                    bt_addr.push_back(bus.mem_addr); bt_be.push_back(bus.mem_be);
                    bt_we.push_back(bus.mem_we);     bt_wdata.push_back(bus.mem_wdata);
                    if (bus.mem_we) begin
                        for (int l = 0; l < 4; l++)
                            if (bus.mem_be[l]) ram[int'(bus.mem_addr) + l] = bus.mem_wdata[8*l +: 8];
                    end else begin
                        for (int l = 0; l < 4; l++) w[8*l +: 8] = ram[int'(bus.mem_addr) + l];
                        rv_at.push_back(cyc + rv_dly);
                        rv_dat.push_back(w);
                    end
                    wait_n = 0; prev_ng = 0;
                end else begin
                    wait_n++; prev_ng = 1;
                    pa = bus.mem_addr; pb = bus.mem_be; pwe = bus.mem_we; pw = bus.mem_wdata;
                end
            end else begin
                prev_ng = 0;
                if (gnt_noise) bus.mem_gnt = 1'($urandom_range(0, 1));
            end
            if (bus.op_ready && !bus.err_pulse && rv_at.size() == 0 && !bus.wb_valid) begin
                done = 1; done_cyc = cyc;
            end
        end
        timed_out = !done;
        repeat (3) begin
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            if (bus.wb_valid) wb_cnt++;
            if (bus.err_pulse) err_cnt++;
            if (bus.mem_req) req_after = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.op_valid = 0; bus.op_is_store = 0; bus.op_funct3 = 0; bus.op_addr = 0;
        bus.op_wdata = 0; bus.op_rd = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        gnt_dly = 0; rv_dly = 1; gnt_noise = 0;
        for (int a = 0; a < 512; a++) begin
            ram[a] = 8'($urandom);
            ref_mem[a] = ram[a];
        end
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.op_ready !== 1'b1) begin $display("FAIL reset_op_ready got %b want 1", bus.op_ready); bad++; end
        total++; if (bus.stall !== 1'b0) begin $display("FAIL reset_stall got %b want 0", bus.stall); bad++; end
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 70'b0) begin
            $display("FAIL reset_mem got req=%b we=%b be=%h addr=%h wd=%h want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); bad++;
        end
        total++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err_pulse} !== 39'b0) begin
            $display("FAIL reset_wb got v=%b rd=%0d d=%h err=%b want all 0",
                     bus.wb_valid, bus.wb_rd, bus.wb_data, bus.err_pulse); bad++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_aligned();
        gnt_dly = 0; gnt_noise = 0;
        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0);
        model_store(32'h10, 3'b010, 32'hDEADBEEF);
        total++; if (timed_out) begin $display("FAIL sw_timeout got timeout want completion"); bad++; end
        total++; if (bt_addr.size() != 1) begin $display("FAIL sw_beats got %0d want 1", bt_addr.size()); bad++; end
        if (bt_addr.size() >= 1) begin
            total++;
            if (bt_addr[0] !== 32'h10 || bt_be[0] !== 4'hF || bt_we[0] !== 1'b1 || bt_wdata[0] !== 32'hDEADBEEF) begin
                $display("FAIL sw_beat got a=%h be=%b we=%b d=%h want 10 1111 1 deadbeef",
                         bt_addr[0], bt_be[0], bt_we[0], bt_wdata[0]); bad++;
            end
        end
        total++; if (done_cyc != 2) begin $display("FAIL sw_ready_cycle got %0d want 2", done_cyc); bad++; end
    endtask

    task automatic test_load_byte();
        set_word(32'h20, 32'h80FF0011);
        gnt_dly = 0; rv_dly = 1; gnt_noise = 0;
        run_op(1'b0, 3'b000, 32'h23, 32'h0, 5'd7);
        total++; if (bt_be.size() != 1 || bt_be[0] !== 4'b1000 || bt_addr[0] !== 32'h20) begin
            $display("FAIL lb_beat got n=%0d want one beat at 20 be 1000", bt_be.size()); bad++; end
        total++; if (wb_dat !== 32'hFFFFFF80 || wb_rd_s !== 5'd7) begin
            $display("FAIL lb_data got %h rd=%0d want ffffff80 rd=7", wb_dat, wb_rd_s); bad++; end
        total++; if (wb_cyc != 3) begin $display("FAIL lb_latency got %0d want 3", wb_cyc); bad++; end
        run_op(1'b0, 3'b100, 32'h23, 32'h0, 5'd9);
        total++; if (wb_dat !== 32'h00000080 || wb_cnt != 1) begin
            $display("FAIL lbu_data got %h cnt=%0d want 00000080 cnt=1", wb_dat, wb_cnt); bad++; end
    endtask

    task automatic test_load_split();
        set_word(32'h08, 32'hAB000000);
        set_word(32'h0C, 32'h000000CD);
        gnt_dly = 0; rv_dly = 1; gnt_noise = 0;
        run_op(1'b0, 3'b001, 32'h0B, 32'h0, 5'd3);
        total++; if (bt_addr.size() != 2) begin $display("FAIL lh_split_beats got %0d want 2", bt_addr.size()); bad++; end
        else begin
            total++;
            if (bt_addr[0] !== 32'h08 || bt_addr[1] !== 32'h0C || bt_be[0] !== 4'b1000 || bt_be[1] !== 4'b0001) begin
                $display("FAIL lh_split_addr got %h/%b %h/%b want 08/1000 0c/0001",
                         bt_addr[0], bt_be[0], bt_addr[1], bt_be[1]); bad++;
            end
        end
        total++; if (wb_dat !== 32'hFFFFCDAB) begin $display("FAIL lh_split_data got %h want ffffcdab", wb_dat); bad++; end
        total++; if (wb_cnt != 1) begin $display("FAIL lh_split_wbcount got %0d want 1", wb_cnt); bad++; end
        total++; if (wb_cyc != 5) begin $display("FAIL lh_split_latency got %0d want 5", wb_cyc); bad++; end
    endtask

    task automatic test_store_split();
        gnt_dly = 0; gnt_noise = 0;
        run_op(1'b1, 3'b010, 32'h06, 32'h11223344, 5'd0);
        model_store(32'h06, 3'b010, 32'h11223344);
        total++; if (bt_addr.size() != 2) begin $display("FAIL sw_split_beats got %0d want 2", bt_addr.size()); bad++; end
        else begin
            total++;
            if (bt_addr[0] !== 32'h04 || bt_be[0] !== 4'b1100 || bt_wdata[0] !== 32'h33440000) begin
                $display("FAIL sw_split_b0 got %h %b %h want 04 1100 33440000", bt_addr[0], bt_be[0], bt_wdata[0]); bad++;
            end
            total++;
            if (bt_addr[1] !== 32'h08 || bt_be[1] !== 4'b0011 || bt_wdata[1] !== 32'h00001122) begin
                $display("FAIL sw_split_b1 got %h %b %h want 08 0011 00001122", bt_addr[1], bt_be[1], bt_wdata[1]); bad++;
            end
        end
        total++; if (done_cyc != 3) begin $display("FAIL sw_split_cycles got %0d want 3", done_cyc); bad++; end
    endtask

    task automatic test_wait_states();
        logic [31:0] w = $urandom;
        set_word(32'h40, w);
        gnt_dly = 3; rv_dly = 2; gnt_noise = 0;
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 5'd31);
        total++; if (unstable) begin $display("FAIL lw_wait_stable got unstable want stable"); bad++; end
        total++; if (stall_gap) begin $display("FAIL lw_wait_stall got stall low while busy want high"); bad++; end
        total++; if (wb_dat !== w || wb_cnt != 1) begin
            $display("FAIL lw_wait_data got %h cnt=%0d want %h cnt=1", wb_dat, wb_cnt, w); bad++; end
        total++; if (wb_cyc != 7) begin $display("FAIL lw_wait_latency got %0d want 7", wb_cyc); bad++; end
    endtask

    task automatic test_reset_mid();
        int wbs = 0, reqs = 0;
        bus.op_valid = 1; bus.op_is_store = 0; bus.op_funct3 = 3'b010; bus.op_addr = 32'h40; bus.op_rd = 5'd5;
        @(posedge clk); #1;
        bus.op_valid = 0; bus.mem_gnt = 1;
        @(posedge clk); #1;
        bus.mem_gnt = 0;
        reset = 1'b1;
        #1;
        total++; if (bus.op_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0) begin
            $display("FAIL mid_reset_async got ready=%b req=%b stall=%b want 1 0 0",
                     bus.op_ready, bus.mem_req, bus.stall); bad++; end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.mem_rvalid = 0;
            if (bus.wb_valid) wbs++;
            if (bus.mem_req) reqs++;
        end
        total++; if (wbs != 0 || reqs != 0) begin $display("FAIL mid_reset_quiet got wb=%0d req=%0d want 0 0", wbs, reqs); bad++; end
        total++; if (bus.op_ready !== 1'b1) begin $display("FAIL mid_reset_ready got %b want 1", bus.op_ready); bad++; end
    endtask

    task automatic test_illegal();
        gnt_dly = 0; gnt_noise = 0;
        run_op(1'b0, 3'b011, 32'h30, 32'h0, 5'd1);
        total++; if (err_cnt != 1 || bt_addr.size() != 0 || wb_cnt != 0) begin
            $display("FAIL illegal_load got err=%0d beats=%0d wb=%0d want 1 0 0", err_cnt, bt_addr.size(), wb_cnt); bad++; end
        run_op(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 5'd1);
        total++; if (err_cnt != 1 || bt_addr.size() != 0 || stall_gap) begin
            $display("FAIL illegal_store got err=%0d beats=%0d stallgap=%b want 1 0 0", err_cnt, bt_addr.size(), stall_gap); bad++; end
    endtask

    task automatic test_random();
        bit st; logic [2:0] f3; logic [31:0] addr, wd, exp; logic [4:0] rd;
        int nb; logic [31:0] wa0, wa1, d0, d1, ea, ed; logic [3:0] be0, be1, eb;
        logic [2:0] ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int k = 0; k < 80; k++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else f3 = st ? 3'($urandom_range(0, 2)) : ld_ok[$urandom_range(0, 4)];
            addr = $urandom_range(0, 32'h1F0); wd = $urandom; rd = 5'($urandom);
            gnt_dly = $urandom_range(0, 2); rv_dly = $urandom_range(1, 3); gnt_noise = 1;
            exp = is_legal(st, f3) ? model_load(addr, f3) : 32'b0;
            run_op(st, f3, addr, wd, rd);
            total++; if (timed_out) begin $display("FAIL rnd_timeout op %0d", k); bad++; end
            total++; if (unstable || stall_gap || req_after) begin
                $display("FAIL rnd_protocol op %0d unstable=%b stallgap=%b req_after=%b want 0 0 0",
                         k, unstable, stall_gap, req_after); bad++; end
            if (!is_legal(st, f3)) begin
                total++; if (err_cnt != 1 || bt_addr.size() != 0 || wb_cnt != 0) begin
                    $display("FAIL rnd_illegal op %0d err=%0d beats=%0d wb=%0d want 1 0 0", k, err_cnt, bt_addr.size(), wb_cnt); bad++; end
            end else begin
                model_beats(addr, size_of(f3), wd, nb, wa0, wa1, be0, be1, d0, d1);
                total++; if (bt_addr.size() != nb || err_cnt != 0) begin
                    $display("FAIL rnd_beats op %0d got %0d err=%0d want %0d err=0", k, bt_addr.size(), err_cnt, nb); bad++; end
                for (int b = 0; b < nb && b < bt_addr.size(); b++) begin
                    ea = (b == 0) ? wa0 : wa1; eb = (b == 0) ? be0 : be1; ed = (b == 0) ? d0 : d1;
                    total++;
                    if (bt_addr[b] !== ea || bt_be[b] !== eb || bt_we[b] !== st ||
                        (st && ((bt_wdata[b] & lane_mask(eb)) !== ed))) begin
                        $display("FAIL rnd_beat op %0d beat %0d got a=%h be=%b we=%b d=%h want a=%h be=%b we=%b d=%h",
                                 k, b, bt_addr[b], bt_be[b], bt_we[b], bt_wdata[b], ea, eb, st, ed); bad++;
                    end
                end
                if (st) begin
                    model_store(addr, f3, wd);
                    total++; if (wb_cnt != 0) begin $display("FAIL rnd_store_wb op %0d got %0d want 0", k, wb_cnt); bad++; end
                end else begin
                    total++; if (wb_cnt != 1 || wb_dat !== exp || wb_rd_s !== rd) begin
                        $display("FAIL rnd_load op %0d f3=%b addr=%h got cnt=%0d d=%h rd=%0d want 1 %h %0d",
                                 k, f3, addr, wb_cnt, wb_dat, wb_rd_s, exp, rd); bad++; end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_aligned();
        test_load_byte();
        test_load_split();
        test_store_split();
        test_wait_states();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
